// File: rtl/counter_load_ctrl_if.sv
`timescale 1ns/1ps
// Bus between the pad-side request source and the counter load front-end.
// The master drives the raw pad-level requests, the slave returns the strobes.
interface counter_load_ctrl_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in_value;
   logic             in_load_req;
   logic             in_write_req;
   logic [WIDTH-1:0] out_load_value;
   logic             out_load_now;
   logic             out_write_now;
   logic             out_busy;
   logic [3:0]       out_load_count;

   modport master (
      output in_value, in_load_req, in_write_req,
      input  out_load_value, out_load_now, out_write_now, out_busy, out_load_count
   );

   modport slave (
      input  in_value, in_load_req, in_write_req,
      output out_load_value, out_load_now, out_write_now, out_busy, out_load_count
   );
endinterface

// File: rtl/counter_load_ctrl.sv
`timescale 1ns/1ps
// Front-end for the loadable counter: synchronises raw pad requests and turns a
// load request into a fixed-length strobe that always wins over write enable.
module counter_load_ctrl #(
   parameter int WIDTH            = 8,
   parameter int SYNC_STAGES      = 2,
   parameter int LOAD_HOLD_CYCLES = 2
) (
   input logic                in_clk,
   input logic                in_rst_n,
   counter_load_ctrl_if.slave bus
);
   localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int HOLD_N = (LOAD_HOLD_CYCLES < 2) ? 2 : LOAD_HOLD_CYCLES;
   localparam int CNT_W  = $clog2(HOLD_N);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_N - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   logic [SYNC_N-1:0] ld_sync_r;
   logic [SYNC_N-1:0] wr_sync_r;
   logic [WIDTH-1:0]  val_sync_r [SYNC_N];
   logic              ld_prev_r;

   logic              ld_s;
   logic              wr_s;
   logic              ld_rise_s;
   logic [WIDTH-1:0]  val_s;

   state_t            state_r;
   logic [CNT_W-1:0]  hold_cnt_r;
   logic [WIDTH-1:0]  load_value_r;
   logic              load_now_r;
   logic              write_now_r;
   logic              busy_r;
   logic [3:0]        load_count_r;

   assign ld_s      = ld_sync_r[SYNC_N-1];
   assign wr_s      = wr_sync_r[SYNC_N-1];
   assign val_s     = val_sync_r[SYNC_N-1];
   assign ld_rise_s = ld_s & ~ld_prev_r;

   // Synchroniser chains for the async pad inputs plus load-request edge history
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         ld_sync_r <= '0;
         wr_sync_r <= '0;
         for (int i = 0; i < SYNC_N; i++) begin
            val_sync_r[i] <= '0;
         end
         ld_prev_r <= 1'b0;
      end else begin
         ld_sync_r     <= {ld_sync_r[SYNC_N-2:0], bus.in_load_req};
         wr_sync_r     <= {wr_sync_r[SYNC_N-2:0], bus.in_write_req};
         val_sync_r[0] <= bus.in_value;
         for (int i = 1; i < SYNC_N; i++) begin
            val_sync_r[i] <= val_sync_r[i-1];
         end
         ld_prev_r <= ld_s;
      end
   end

   // Load FSM; write enable is only granted when the FSM will be IDLE next cycle
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_r      <= ST_IDLE;
         hold_cnt_r   <= '0;
         load_value_r <= '0;
         load_now_r   <= 1'b0;
         write_now_r  <= 1'b0;
         busy_r       <= 1'b0;
         load_count_r <= 4'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (ld_rise_s) begin
                  state_r      <= ST_HOLD;
                  load_value_r <= val_s;
                  load_now_r   <= 1'b1;
                  hold_cnt_r   <= '0;
                  load_count_r <= load_count_r + 4'd1;
                  busy_r       <= 1'b1;
                  write_now_r  <= 1'b0;
               end else begin
                  state_r     <= ST_IDLE;
                  load_now_r  <= 1'b0;
                  busy_r      <= 1'b0;
                  write_now_r <= wr_s;
               end
            end
            ST_HOLD: begin
               busy_r      <= 1'b1;
               write_now_r <= 1'b0;
               // A request dropping early must not shorten the strobe
               if (hold_cnt_r == HOLD_LAST) begin
                  state_r    <= ST_RELEASE;
                  load_now_r <= 1'b0;
               end else begin
                  hold_cnt_r <= hold_cnt_r + CNT_ONE;
                  load_now_r <= 1'b1;
               end
            end
            ST_RELEASE: begin
               load_now_r <= 1'b0;
               if (!ld_s) begin
                  state_r     <= ST_IDLE;
                  busy_r      <= 1'b0;
                  write_now_r <= wr_s;
               end else begin
                  state_r     <= ST_RELEASE;
                  busy_r      <= 1'b1;
                  write_now_r <= 1'b0;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               hold_cnt_r  <= '0;
               load_now_r  <= 1'b0;
               write_now_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out_load_value = load_value_r;
   assign bus.out_load_now   = load_now_r;
   assign bus.out_write_now  = write_now_r;
   assign bus.out_busy       = busy_r;
   assign bus.out_load_count = load_count_r;
endmodule
